// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between dmem_access_ctrl (master) and the DMEM responder (slave).
// Handshake: the master raises MEM_REQ and holds MEM_WE/ADDR/BE/WDATA stable until it samples MEM_ACK high; that edge completes the transfer and MEM_RDATA is valid with it.
interface dmem_access_ctrl_if;
   logic        MEM_REQ;
   logic        MEM_WE;
   logic [31:0] MEM_ADDR;
   logic [3:0]  MEM_BE;
   logic [31:0] MEM_WDATA;
   logic        MEM_ACK;
   logic [31:0] MEM_RDATA;

   modport master (
      output MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA,
      input  MEM_ACK, MEM_RDATA
   );

   modport slave (
      input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA,
      output MEM_ACK, MEM_RDATA
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for the data memory: byte/half/word access with alignment check and load extension.
// Optional macro DMEM_TIMEOUT_EN aborts a request that sees no MEM_ACK within TIMEOUT_CYC cycles.
module dmem_access_ctrl #(
   parameter int DMEM_WORDS  = 64,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                START,
   input  logic                WE,
   input  logic [1:0]          SIZE,
   input  logic                SEXT,
   input  logic [31:0]         ADDR,
   input  logic [31:0]         WDATA,
   output logic                BUSY,
   output logic                DONE,
   output logic                ERR,
   output logic [31:0]         RDATA,
   output logic [1:0]          dbg_state,
   dmem_access_ctrl_if.master  mem
);

   localparam int AW = $clog2(DMEM_WORDS);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

   state_t        state, state_nxt;
   logic          we_q, err_q, sext_q;
   logic [1:0]    size_q, lane_q;
   logic [AW-1:0] idx_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q, rdata_q;

   logic          mis;
   logic [3:0]    be_c;
   logic [31:0]   wd_c, shifted, ld_word;
   logic          timeout;
   logic          unused_addr;

   assign unused_addr = ^ADDR[31:AW+2];

   // Command decode straight from the execute-stage inputs, used only at accept.
   always_comb begin
      mis  = 1'b1;
      be_c = 4'b1111;
      wd_c = WDATA;
      case (SIZE)
         2'b00: begin
            mis  = 1'b0;
            be_c = 4'b0001 << ADDR[1:0];
            wd_c = {4{WDATA[7:0]}};
         end
         2'b01: begin
            mis  = ADDR[0];
            be_c = 4'b0011 << ADDR[1:0];
            wd_c = {2{WDATA[15:0]}};
         end
         2'b10:   mis = |ADDR[1:0];
         default: mis = 1'b1;
      endcase
   end

   always_comb begin
      shifted = mem.MEM_RDATA >> {lane_q, 3'b000};
      case (size_q)
         2'b00:   ld_word = {{24{sext_q & shifted[7]}}, shifted[7:0]};
         2'b01:   ld_word = {{16{sext_q & shifted[15]}}, shifted[15:0]};
         default: ld_word = mem.MEM_RDATA;
      endcase
   end

`ifdef DMEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] tmo_cnt;

   // Counts completed REQ cycles; held at zero outside REQ so each request starts fresh.
   always_ff @(posedge CLK) begin
      if (RST || state != REQ) tmo_cnt <= '0;
      else if (!mem.MEM_ACK)   tmo_cnt <= tmo_cnt + 1'b1;
   end
   assign timeout = (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (START) state_nxt = mis ? RESP : REQ;
         REQ:     if (mem.MEM_ACK || timeout) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         sext_q  <= 1'b0;
         size_q  <= 2'b00;
         lane_q  <= 2'b00;
         idx_q   <= '0;
         be_q    <= 4'b0000;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (START) begin
               err_q <= mis;
               if (!mis) begin
                  we_q    <= WE;
                  sext_q  <= SEXT;
                  size_q  <= SIZE;
                  lane_q  <= ADDR[1:0];
                  idx_q   <= ADDR[AW+1:2];
                  be_q    <= be_c;
                  wdata_q <= wd_c;
               end
            end
            REQ: if (mem.MEM_ACK) begin
               if (!we_q) rdata_q <= ld_word;
            end else if (timeout) begin
               err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign BUSY          = (state != IDLE);
   assign DONE          = (state == RESP);
   assign ERR           = DONE & err_q;
   assign RDATA         = rdata_q;
   assign dbg_state     = state;
   assign mem.MEM_REQ   = (state == REQ);
   assign mem.MEM_WE    = (state == REQ) & we_q;
   assign mem.MEM_ADDR  = {{(32-AW){1'b0}}, idx_q};
   assign mem.MEM_BE    = be_q;
   assign mem.MEM_WDATA = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed cases plus random loads/stores checked each cycle against a behavioural model.
module tb_dmem_access_ctrl;
   localparam int DEPTH = 64;
   localparam int TMO   = 16;
   localparam int W     = 105;

   logic        CLK = 1'b0;
   logic        RST, START, WE, SEXT;
   logic [1:0]  SIZE;
   logic [31:0] ADDR, WDATA;
   logic        BUSY, DONE, ERR;
   logic [31:0] RDATA;
   logic [1:0]  dbg_state;

   dmem_access_ctrl_if bus();

   dmem_access_ctrl #(.DMEM_WORDS(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .CLK(CLK), .RST(RST), .START(START), .WE(WE), .SIZE(SIZE), .SEXT(SEXT),
      .ADDR(ADDR), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
      .RDATA(RDATA), .dbg_state(dbg_state), .mem(bus)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   int          total = 0;
   int          bad = 0;
   bit          checking = 1'b0;
   logic [31:0] exp_rdata = 32'h0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] e;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_done, last_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model
   function automatic bit model_mis(input logic [1:0] size, input logic [31:0] addr);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return (addr % 2) != 0;
         2'd2:    return (addr % 4) != 0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
      int lane;
      lane = int'(addr % 4);
      case (size)
         2'd0:    return 4'(1 << lane);
         2'd1:    return 4'(3 << lane);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'd0:    return 32'(wd[7:0]) * 32'h01010101;
         2'd1:    return 32'(wd[15:0]) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                              input bit sext, input logic [31:0] addr);
      int b[4];
      int lane, v;
      for (int i = 0; i < 4; i++) b[i] = int'((word / (32'd1 << (8 * i))) % 256);
      lane = int'(addr % 4);
      if (size == 2'd0) begin
         v = b[lane];
         if (sext && v >= 128) v = v - 256;
         return 32'(v);
      end else if (size == 2'd1) begin
         v = b[lane] + 256 * b[lane + 1];
         if (sext && v >= 32768) v = v - 65536;
         return 32'(v);
      end
      return word;
   endfunction

   task automatic push(input bit busy, done, err, req, we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, rd);
      exp_q.push_back({busy, done, err, req, we, addr, be, wd, rd});
   endtask

   // scoreboard compare, one entry per cycle while a command is in flight
   always @(negedge CLK) begin
      if (checking) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy",   32'(BUSY),        32'(e[104]));
            check("done",   32'(DONE),        32'(e[103]));
            check("err",    32'(ERR),         32'(e[102]));
            check("req",    32'(bus.MEM_REQ), 32'(e[101]));
            check("mem_we", 32'(bus.MEM_WE),  32'(e[100]));
            check("rdata",  RDATA,            e[31:0]);
            if (e[101]) begin
               check("mem_addr",  bus.MEM_ADDR,      e[99:68]);
               check("mem_be",    32'(bus.MEM_BE),   32'(e[67:64]));
               check("mem_wdata", bus.MEM_WDATA,     e[63:32]);
            end
         end else begin
            check("idle_busy",  32'(BUSY),        32'd0);
            check("idle_done",  32'(DONE),        32'd0);
            check("idle_req",   32'(bus.MEM_REQ), 32'd0);
            check("idle_rdata", RDATA,            exp_rdata);
         end
      end
   end

   // driver: issues one command and plays the memory responder with ack delay d
   task automatic do_cmd(input bit we, input logic [1:0] size, input bit sext,
                         input logic [31:0] addr, wd, input int d, input logic [31:0] rword,
                         input bit no_ack, input bit poke);
      bit mis;
      int nreq;
      logic [31:0] idx, new_rd;
      @(posedge CLK); #1;
      START = 1'b1; WE = we; SIZE = size; SEXT = sext; ADDR = addr; WDATA = wd;
      @(posedge CLK); #1;
      START = 1'b0; WE = 1'($urandom); SIZE = 2'($urandom); SEXT = 1'($urandom);
      ADDR = $urandom; WDATA = $urandom;
      mis = model_mis(size, addr);
      idx = (addr / 4) % DEPTH;
      if (mis) begin
         push(1, 1, 1, 0, 0, 0, 0, 0, exp_rdata);
      end else begin
         nreq   = no_ack ? TMO : d + 1;
         new_rd = (!we && !no_ack) ? model_load(rword, size, sext, addr) : exp_rdata;
         for (int k = 0; k < nreq; k++)
            push(1, 0, 0, 1, we, idx, model_be(size, addr), model_wdata(size, wd), exp_rdata);
         push(1, 1, no_ack, 0, 0, 0, 0, 0, new_rd);
         exp_rdata = new_rd;
         for (int k = 0; k < nreq; k++) begin
            bus.MEM_ACK   = !no_ack && (k == d);
            bus.MEM_RDATA = (k == d) ? rword : $urandom;
            if (k == d) begin
               last_addr = bus.MEM_ADDR; last_be = bus.MEM_BE; last_wdata = bus.MEM_WDATA;
            end
            @(posedge CLK); #1;
         end
         bus.MEM_ACK = 1'b0;
      end
      last_done = DONE;
      last_err  = ERR;
      if (poke) begin
         START = 1'b1; WE = 1'b0; SIZE = 2'd2; ADDR = 32'h0;
      end
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   initial begin
      RST = 1'b1; START = 1'b1; WE = 1'b1; SIZE = 2'd2; SEXT = 1'b0;
      ADDR = 32'h4; WDATA = $urandom;
      bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 32'h0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_busy",  32'(BUSY),          32'd0);
      check("rst_done",  32'(DONE),          32'd0);
      check("rst_err",   32'(ERR),           32'd0);
      check("rst_req",   32'(bus.MEM_REQ),   32'd0);
      check("rst_we",    32'(bus.MEM_WE),    32'd0);
      check("rst_addr",  bus.MEM_ADDR,       32'd0);
      check("rst_be",    32'(bus.MEM_BE),    32'd0);
      check("rst_wdata", bus.MEM_WDATA,      32'd0);
      check("rst_rdata", RDATA,              32'd0);
      RST = 1'b0; START = 1'b0;
      checking = 1'b1;

      // store word, ack one cycle after request rises
      do_cmd(1, 2'd2, 0, 32'h8, 32'hDEADBEEF, 1, 32'h0, 0, 0);
      check("sw_addr",  last_addr,        32'd2);
      check("sw_be",    32'(last_be),     32'hF);
      check("sw_wdata", last_wdata,       32'hDEADBEEF);
      check("sw_done",  32'(last_done),   32'd1);
      check("sw_err",   32'(last_err),    32'd0);

      // byte loads, signed then unsigned
      do_cmd(0, 2'd0, 1, 32'h0B, 32'h0, 0, 32'h80112233, 0, 0);
      check("lb_sext", RDATA, 32'hFFFFFF80);
      do_cmd(0, 2'd0, 0, 32'h0B, 32'h0, 0, 32'h80112233, 0, 1);
      check("lb_zext", RDATA, 32'h00000080);

      // store half with address wrap
      do_cmd(1, 2'd1, 0, 32'h102, 32'h1234, 0, 32'h0, 0, 0);
      check("sh_addr",  last_addr,     32'd0);
      check("sh_be",    32'(last_be),  32'hC);
      check("sh_wdata", last_wdata,    32'h12341234);

      // misaligned word never reaches memory and keeps RDATA
      do_cmd(0, 2'd2, 0, 32'h6, 32'h0, 0, 32'h0, 0, 0);
      check("mis_done",  32'(last_done), 32'd1);
      check("mis_err",   32'(last_err),  32'd1);
      check("mis_rdata", RDATA,          32'h00000080);

      // slow memory
      do_cmd(0, 2'd1, 1, 32'h22, 32'h0, 5, 32'h9ABC0000, 0, 0);
      check("lh_slow", RDATA, 32'hFFFF9ABC);

`ifdef DMEM_TIMEOUT_EN
      do_cmd(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h0, 1, 0);
      check("tmo_err", 32'(last_err), 32'd1);
`endif

      // reset while a request is outstanding
      checking = 1'b0;
      @(posedge CLK); #1;
      START = 1'b1; WE = 1'b0; SIZE = 2'd2; ADDR = 32'h20;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (2) begin @(posedge CLK); #1; end
      check("mid_req", 32'(bus.MEM_REQ), 32'd1);
      RST = 1'b1;
      @(posedge CLK); #1;
      check("mid_req_drop", 32'(bus.MEM_REQ), 32'd0);
      check("mid_busy",     32'(BUSY),        32'd0);
      check("mid_done",     32'(DONE),        32'd0);
      RST = 1'b0;
      exp_rdata = 32'h0;
      @(posedge CLK); #1;
      check("mid_no_done", 32'(DONE), 32'd0);
      checking = 1'b1;

      // random traffic
      for (int n = 0; n < 80; n++) begin
         int r;
         logic [1:0]  sz;
         logic [31:0] a;
         r  = $urandom_range(0, 9);
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         do_cmd(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 6),
                $urandom, 0, $urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 2)) @(posedge CLK);
         #1;
      end

      repeat (3) @(posedge CLK);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end
endmodule
